hwag_regbus_arb: RTL and testbench

Two-port arbiter and sequencer for the hwag 64 × 16 register file (SSRAM port). It shares the single register-file bus between the external host port (port 0) and the internal tooth/angle status engine (port 1). It serialises their single-word read and write transactions with a fixed four-state bus sequence and per-port req/ack handshakes. It also rejects out-of-range addresses without touching the register file.

---
 rtl/hwag_pkg.sv | 15 +
 rtl/hwag_regbus_arb_if.sv | 36 +++
 rtl/hwag_arb_pick.sv | 29 ++
 rtl/hwag_regbus_arb.sv | 138 +++++++++++++
 tb/tb_hwag_regbus_arb.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwag_pkg.sv
// Shared definitions for the hwag register-file bus: sizes and arbiter state encoding.
package hwag_pkg;

  localparam int HWAG_REG_COUNT = 64;
  localparam int HWAG_ADDR_W    = 8;
  localparam int HWAG_DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/hwag_regbus_arb_if.sv
// Requester-side handshake and SSRAM-side bus of the hwag register-file arbiter.
// slave modport: the arbiter's view; master modport: requesters plus register file.
interface hwag_regbus_arb_if
  import hwag_pkg::*;
#(
  parameter int ADDR_W = HWAG_ADDR_W,
  parameter int DATA_W = HWAG_DATA_W
);

  logic [1:0]        req;
  logic [1:0]        we_in;
  logic [1:0]        lock;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              ssram_we;
  logic              ssram_re;
  logic [ADDR_W-1:0] ssram_addr;
  logic [DATA_W-1:0] ssram_wdata;
  logic [DATA_W-1:0] ssram_rdata;

  modport slave (
    input  req, we_in, lock, addr0, addr1, wdata0, wdata1, ssram_rdata,
    output ack, err, rdata, ssram_we, ssram_re, ssram_addr, ssram_wdata
  );

  modport master (
    output req, we_in, lock, addr0, addr1, wdata0, wdata1, ssram_rdata,
    input  ack, err, rdata, ssram_we, ssram_re, ssram_addr, ssram_wdata
  );

endinterface

// File: rtl/hwag_arb_pick.sv
// Combinational winner selection between the host port (0) and the status engine (1).
// Build option: HWAG_ARB_FIXED_PRIO_EN makes port 0 win every tie and ignores the pointer.
module hwag_arb_pick (
  input  logic [1:0] req_i,
  input  logic       pointer_i,
  output logic       valid_o,
  output logic       winner_o
);

  assign valid_o = |req_i;

`ifdef HWAG_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = pointer_i;

  // Port 0 takes any tie; port 1 only wins when it requests alone.
  always_comb begin
    winner_o = 1'b0;
    if (!req_i[0] && req_i[1]) winner_o = 1'b1;
  end
`else
  // The pointer port wins if it requests, otherwise whoever requests.
  always_comb begin
    winner_o = pointer_i;
    if (!req_i[pointer_i]) winner_o = ~pointer_i;
  end
`endif

endmodule

// File: rtl/hwag_regbus_arb.sv
// Two-port arbiter/sequencer for the hwag 64x16 register file (SSRAM port).
// Build option: HWAG_ARB_FIXED_PRIO_EN selects fixed priority (port 0) and drops
// the round-robin pointer and lock handling.
//
// state  | meaning
// IDLE   | sample req, latch winner's we/addr/wdata
// ACCESS | drive one SSRAM strobe, or flag an out-of-range address
// RWAIT  | capture SSRAM read data
// DONE   | ack the granted port, advance the pointer
module hwag_regbus_arb
  import hwag_pkg::*;
#(
  parameter int REG_COUNT = HWAG_REG_COUNT,
  parameter int ADDR_W    = HWAG_ADDR_W,
  parameter int DATA_W    = HWAG_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  hwag_regbus_arb_if.slave bus
);

  localparam logic [ADDR_W:0] REG_LIMIT = REG_COUNT[ADDR_W:0];

  arb_state_t        state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pick_valid, pick_winner, pick_ptr;
  logic in_range;

  assign in_range = ({1'b0, addr_q} < REG_LIMIT);

  hwag_arb_pick u_pick (
    .req_i     (bus.req),
    .pointer_i (pick_ptr),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

`ifdef HWAG_ARB_FIXED_PRIO_EN
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign pick_ptr    = 1'b0;
`else
  logic ptr_q, ptr_d;

  // Pointer register: names the port preferred on the next tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

  // On completion hand preference to the other port unless the winner holds lock.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DONE) ptr_d = bus.lock[grant_q] ? grant_q : ~grant_q;
  end

  assign pick_ptr = ptr_q;
`endif

  // State and transaction latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and latch updates; requester inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          we_d    = bus.we_in[pick_winner];
          addr_d  = pick_winner ? bus.addr1 : bus.addr0;
          wdata_d = pick_winner ? bus.wdata1 : bus.wdata0;
          err_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!in_range) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        rdata_d = bus.ssram_rdata;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes come straight off the state register so reset removes them at once.
  assign bus.ssram_we    = (state_q == ACCESS) && we_q && in_range;
  assign bus.ssram_re    = (state_q == ACCESS) && !we_q && in_range;
  assign bus.ssram_addr  = addr_q;
  assign bus.ssram_wdata = wdata_q;
  assign bus.ack         = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.err         = (state_q == DONE) && err_q;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_hwag_regbus_arb.sv
// Bench for hwag_regbus_arb: directed scenarios plus random two-port traffic,
// checked every cycle against a transaction-level timing/data model.
module tb_hwag_regbus_arb;

`ifdef HWAG_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  hwag_regbus_arb_if bus ();

  hwag_regbus_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    if (i == 5) return 16'h1234;
    return 16'(i * 1841 + 23130);
  endfunction

  // Register file behaviour: write on strobe, read data one cycle after read strobe.
  logic [15:0] mem [0:255];
  logic [15:0] rd_q;
  assign bus.ssram_rdata = rd_q;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      rd_q <= 16'h0;
    end else begin
      if (bus.ssram_we) mem[bus.ssram_addr] <= bus.ssram_wdata;
      if (bus.ssram_re) rd_q <= mem[bus.ssram_addr];
    end
  end

  // Reference model: one transaction at a time; a transaction started at a sample edge
  // strobes in the next cycle and acks 2 cycles (write/error) or 3 cycles (read) later.
  logic [15:0] shadow [0:255];
  bit          m_busy, m_we, m_inr;
  int          m_cnt, m_len, m_port, m_ptr;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [1:0]  exp_ack;
  bit          exp_err, exp_we, exp_re;

  always @(posedge clk or negedge rst) begin
    if (mem_init) for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_rdata = 16'h0;
      exp_ack = 2'b00; exp_err = 0; exp_we = 0; exp_re = 0;
    end else begin
      if (m_busy) begin
        if (m_cnt == m_len) begin
          m_ptr  = bus.lock[m_port] ? m_port : 1 - m_port;
          m_busy = 0;
        end else begin
          m_cnt++;
        end
      end else if (bus.req != 2'b00) begin
        if (bus.req == 2'b11) m_port = FIXED_PRIO ? 0 : m_ptr;
        else                  m_port = bus.req[1] ? 1 : 0;
        m_we    = bus.we_in[m_port];
        m_addr  = (m_port == 1) ? bus.addr1 : bus.addr0;
        m_wdata = (m_port == 1) ? bus.wdata1 : bus.wdata0;
        m_inr   = (m_addr < 8'd64);
        m_len   = (m_inr && !m_we) ? 3 : 2;
        m_cnt   = 1;
        m_busy  = 1;
      end
      exp_ack = 2'b00; exp_err = 0; exp_we = 0; exp_re = 0;
      if (m_busy && m_cnt == 1) begin
        exp_we = m_we && m_inr;
        exp_re = !m_we && m_inr;
      end
      if (m_busy && m_cnt == m_len) begin
        exp_ack[m_port] = 1'b1;
        exp_err = !m_inr;
        if (!m_inr)     m_rdata = 16'h0;
        else if (!m_we) m_rdata = shadow[m_addr];
        else            shadow[m_addr] = m_wdata;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and compare the bus against the model.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      check_eq("ack", 32'(bus.ack), 32'(exp_ack));
      check_eq("ssram_we", 32'(bus.ssram_we), 32'(exp_we));
      check_eq("ssram_re", 32'(bus.ssram_re), 32'(exp_re));
      if (exp_we || exp_re) check_eq("ssram_addr", 32'(bus.ssram_addr), 32'(m_addr));
      if (exp_we) check_eq("ssram_wdata", 32'(bus.ssram_wdata), 32'(m_wdata));
      if (exp_ack != 2'b00) begin
        check_eq("err", 32'(bus.err), 32'(exp_err));
        check_eq("rdata", 32'(bus.rdata), 32'(m_rdata));
      end
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit we, input logic [7:0] a,
                          input logic [15:0] d, input bit lk);
    bus.req[p]   = r;
    bus.we_in[p] = we;
    bus.lock[p]  = lk;
    if (p == 0) begin bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.addr1 = a; bus.wdata1 = d; end
  endtask

  task automatic wait_ack(input int p, output int lat);
    int c0;
    c0  = cyc;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ack[p]) begin
        lat = cyc - c0;
        break;
      end
    end
    if (lat < 0) check_eq("ack_seen", 32'(bus.ack[p]), 32'd1);
  endtask

  task automatic collect_grants(output int g[$]);
    g = {};
    for (int i = 0; i < 40 && g.size() < 4; i++) begin
      tick();
      if (bus.ack[0]) g.push_back(0);
      else if (bus.ack[1]) g.push_back(1);
    end
    check_eq("arb_acks", g.size(), 4);
  endtask

  initial begin
    int lat;
    int g[$];
    logic [15:0] d;

    rst = 1'b0;
    mem_init = 1'b1;
    bus.req = 2'b00; bus.we_in = 2'b00; bus.lock = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    check_eq("rst_ack", 32'(bus.ack), 0);
    check_eq("rst_err", 32'(bus.err), 0);
    check_eq("rst_rdata", 32'(bus.rdata), 0);
    check_eq("rst_we", 32'(bus.ssram_we), 0);
    check_eq("rst_re", 32'(bus.ssram_re), 0);
    check_eq("rst_addr", 32'(bus.ssram_addr), 0);
    check_eq("rst_wdata", 32'(bus.ssram_wdata), 0);
    rst = 1'b1;
    tick();

    // Port 0 write addr 0 data 3.
    set_port(0, 1, 1, 8'd0, 16'h0003, 0);
    wait_ack(0, lat);
    check_eq("wr_lat", lat, 2);
    check_eq("wr_err", 32'(bus.err), 0);
    check_eq("wr_mem0", 32'(mem[0]), 32'h3);
    bus.req[0] = 1'b0;
    tick();

    // Port 1 read of preloaded register 5.
    set_port(1, 1, 0, 8'd5, 16'h0, 0);
    wait_ack(1, lat);
    check_eq("rd_lat", lat, 3);
    check_eq("rd_data", 32'(bus.rdata), 32'h1234);
    bus.req[1] = 1'b0;
    tick();

    // Both ports reading continuously, no lock.
    set_port(0, 1, 0, 8'd1, 16'h0, 0);
    set_port(1, 1, 0, 8'd2, 16'h0, 0);
    collect_grants(g);
    bus.req = 2'b00;
    tick();
    for (int i = 1; i < 4 && i < g.size(); i++) begin
      if (FIXED_PRIO) check_eq("fixed_grant", g[i], 0);
      else            check_eq("rr_alternate", 32'(g[i] != g[i-1]), 1);
    end

    // Same, with port 1 holding lock.
    set_port(0, 1, 0, 8'd3, 16'h0, 0);
    set_port(1, 1, 0, 8'd4, 16'h0, 1);
    collect_grants(g);
    bus.req = 2'b00;
    bus.lock = 2'b00;
    tick();
    for (int i = 1; i < 4 && i < g.size(); i++)
      check_eq("lock_grant", g[i], FIXED_PRIO ? 0 : 1);

    // Out-of-range writes and the last valid address.
    set_port(0, 1, 1, 8'd64, 16'hbeef, 0);
    wait_ack(0, lat);
    check_eq("err64_lat", lat, 2);
    check_eq("err64_err", 32'(bus.err), 1);
    check_eq("err64_rdata", 32'(bus.rdata), 0);
    bus.req[0] = 1'b0;
    tick();
    set_port(0, 1, 1, 8'd255, 16'hcafe, 0);
    wait_ack(0, lat);
    check_eq("err255_err", 32'(bus.err), 1);
    bus.req[0] = 1'b0;
    tick();
    check_eq("mem64_kept", 32'(mem[64]), 32'(init_val(64)));
    check_eq("mem255_kept", 32'(mem[255]), 32'(init_val(255)));
    d = 16'($urandom);
    set_port(0, 1, 1, 8'd63, d, 0);
    wait_ack(0, lat);
    check_eq("wr63_lat", lat, 2);
    check_eq("wr63_err", 32'(bus.err), 0);
    bus.req[0] = 1'b0;
    tick();
    set_port(1, 1, 0, 8'd63, 16'h0, 0);
    wait_ack(1, lat);
    check_eq("rd63_data", 32'(bus.rdata), 32'(d));
    bus.req[1] = 1'b0;
    tick();

    // Reset during ACCESS of a port 1 write; request stays up and is re-issued.
    d = 16'($urandom);
    set_port(1, 1, 1, 8'd10, d, 0);
    tick();
    check_eq("pre_rst_we", 32'(bus.ssram_we), 1);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(bus.ssram_we), 0);
    check_eq("mid_rst_re", 32'(bus.ssram_re), 0);
    check_eq("mid_rst_ack", 32'(bus.ack), 0);
    check_eq("mid_rst_err", 32'(bus.err), 0);
    check_eq("mid_rst_rdata", 32'(bus.rdata), 0);
    check_eq("mid_rst_addr", 32'(bus.ssram_addr), 0);
    check_eq("mid_rst_wdata", 32'(bus.ssram_wdata), 0);
    tick();
    tick();
    check_eq("mid_rst_mem10", 32'(mem[10]), 32'(init_val(10)));
    rst = 1'b1;
    wait_ack(1, lat);
    check_eq("reissue_lat", lat, 2);
    check_eq("reissue_err", 32'(bus.err), 0);
    check_eq("reissue_mem10", 32'(mem[10]), 32'(d));
    bus.req[1] = 1'b0;
    tick();

    // Random traffic on both ports; last cycles only drain.
    for (int c = 0; c < 412; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (bus.req[p] && !bus.ack[p]) continue;
        if (c < 400 && $urandom_range(3) != 0) begin
          set_port(p, 1, 1'($urandom_range(1)),
                   ($urandom_range(3) == 0) ? 8'($urandom_range(255, 64)) : 8'($urandom_range(63)),
                   16'($urandom), ($urandom_range(3) == 0));
        end else begin
          bus.req[p] = 1'b0;
        end
      end
    end
    bus.req = 2'b00;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
